result_mem_arbiter: RTL
=======================

Name: result_mem_arbiter

Overview:
- Shares the single-port result SRAM between two requesters: ALU write-back, which fills the 4x4 result matrix column by column, and host readout of finished results.
- Buffers ALU results in a small FIFO and generates sequential write addresses.
- Grants one SRAM access per cycle, with write priority bounded by a streak limit.
- Sits between the ALU/controller and the result memory; signals write-back completion back to the controller.

Parameters:
- DATA_W, 32, width of one result word
- ADDR_W, 4, result SRAM address width (16 entries = 4 cols x 4 rows)
- NUM_RESULTS, 16, writes per matrix before wb_done
- MAX_WR_STREAK, 3, consecutive write grants allowed while a read is pending

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  pulse: new matrix; clears write pointer, FIFO, streak
- wr_valid  in  1  ALU result available
- wr_data  in  DATA_W  ALU result word
- wr_ready  out  1  FIFO can accept (not full)
- rd_req  in  1  host read request, held until rd_gnt
- rd_addr  in  ADDR_W  read address, stable while rd_req high
- rd_gnt  out  1  read access issued this cycle
- rd_valid  out  1  rd_data valid (cycle after rd_gnt)
- rd_data  out  DATA_W  read data (mem_rdata passthrough)
- mem_csn  out  1  SRAM chip select, active low
- mem_web  out  1  SRAM write enable, active low
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data (FIFO head)
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after read access
- wb_done  out  1  one-cycle pulse when the NUM_RESULTS-th write is issued

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst). Reset clears FIFO, write pointer, streak counter and state=IDLE.
- Reset values: wr_ready=1, rd_gnt=0, rd_valid=0, mem_csn=1, mem_web=1, wb_done=0.
- FIFO: 2 entries. Push when wr_valid&&wr_ready. wr_ready=!full. A push and a pop in the same cycle are legal when not full.
- Arbitration is combinational per cycle:
  - wr_pend = FIFO non-empty.
  - Read wins if rd_req && (!wr_pend || streak==MAX_WR_STREAK); else write wins if wr_pend; else no access.
- Write grant:
  - mem_csn=0, mem_web=0, mem_addr=wr_ptr, mem_wdata=FIFO head.
  - Pop FIFO; wr_ptr increments.
  - If wr_ptr==NUM_RESULTS-1, wr_ptr wraps to 0 and wb_done pulses in that same cycle.
- Read grant: mem_csn=0, mem_web=1, mem_addr=rd_addr, rd_gnt=1. rd_valid is registered rd_gnt, so it asserts the next cycle.
- Streak counter:
  - Increments on a write grant while rd_req=1.
  - Clears on a read grant or whenever rd_req=0.
  - Saturates at MAX_WR_STREAK.
- State register (IDLE/WR/RD) records the last granted op; RD→rd_valid next cycle.
- start: synchronous clear of FIFO, wr_ptr and streak the next edge. Writes pushed in the start cycle are dropped. A read granted in the start cycle still completes (rd_valid next cycle).
- After a grant, the host drops rd_req or presents the next address. rd_req held high after rd_gnt counts as a new request.
- Reset mid-operation: everything is cleared immediately; an in-flight rd_valid is suppressed.

Optional Feature:
- Macro: WR_STREAK_LIMIT_EN.
- Defined: streak fairness as above.
- Undefined: strict write priority. Reads are granted only when the FIFO is empty; the streak counter is not implemented.

Decomposition:
- Shared package holds:
  - State encoding IDLE=2'b00, WR=2'b01, RD=2'b10.
  - Default DATA_W/ADDR_W/NUM_RESULTS constants shared with the controller and ALU.
- One sub-module: wb_fifo (2-entry, valid/ready push, pop/empty, full flag).

Test Plan:
- Reset then idle: rst low mid-stream → all outputs at reset values; mem_csn=1 while no requests.
- 16 back-to-back wr_valid, data 0..15, no reads → mem_addr 0..15 with mem_wdata equal to addr; wb_done pulses exactly with addr 15; wr_ptr wraps to 0.
- Read only: rd_req, rd_addr=5 with SRAM preloaded 0xA5 → rd_gnt same cycle, rd_valid+rd_data=0xA5 next cycle.
- Contention, streak enabled: continuous writes plus rd_req held → pattern W,W,W,R repeats; rd_gnt on the 4th cycle; streak resets.
- Contention, macro undefined: same stimulus → rd_gnt only after the FIFO drains; wr_ready deasserts when 2 entries are pending and no pop occurs.
- start pulse with 1 FIFO entry and wr_ptr=7 → FIFO empty, next write goes to addr 0, no wb_done.

Source files
------------

// File: rtl/result_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// result_mem_arbiter_pkg
// Shared definitions for the result-memory arbiter, the matrix controller and
// the ALU. It holds the arbiter state encoding and the default geometry of the
// result matrix, which is 4 columns x 4 rows of DATA_W-bit words.
// -----------------------------------------------------------------------------
package result_mem_arbiter_pkg;

  // Records the last granted SRAM operation.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR   = 2'b01,
    RD   = 2'b10
  } arb_state_e;

  localparam int DEF_DATA_W        = 32;
  localparam int DEF_ADDR_W        = 4;
  localparam int DEF_NUM_RESULTS   = 16;
  localparam int DEF_MAX_WR_STREAK = 3;

endpackage

// File: rtl/result_mem_arbiter_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// A 2-entry write-back FIFO that holds ALU results until the arbiter grants
// them an SRAM write slot.
//
// Ports
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset (pointers and count only)
//   clr_i    synchronous clear; it wins over a push or pop in the same cycle
//   push_i   push request; accepted only when the FIFO is not full
//   data_i   word to push
//   pop_i    pop request; ignored when the FIFO is empty
//   data_o   head of the FIFO; valid while empty_o is low
//   empty_o  no entries held
//   full_o   both entries held
// -----------------------------------------------------------------------------
module wb_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is refused even when a pop happens in the same
  // cycle, so the producer only needs to look at full_o.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset because the count marks which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/result_mem_arbiter.sv
// -----------------------------------------------------------------------------
// result_mem_arbiter
// Shares the single-port result SRAM between ALU write-back and host readout.
// ALU results are buffered in a 2-entry FIFO and written to sequential
// addresses 0..NUM_RESULTS-1, which fills the matrix column by column.
// wb_done pulses in the cycle that issues the last write of a matrix.
// Only one SRAM access is granted per cycle.
//
// Build option
//   WR_STREAK_LIMIT_EN  defined: a pending read waits for at most
//                       MAX_WR_STREAK consecutive write grants.
//                       undefined: writes have strict priority, so a read is
//                       granted only when the FIFO is empty.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      new-matrix pulse; clears the FIFO, write pointer and streak
//   wr_valid   ALU result available
//   wr_data    ALU result word
//   wr_ready   FIFO not full
//   rd_req     host read request, held until rd_gnt
//   rd_addr    host read address
//   rd_gnt     read access issued this cycle
//   rd_valid   rd_data valid (the cycle after rd_gnt)
//   rd_data    read data (passthrough of mem_rdata)
//   mem_csn    SRAM chip select, active low
//   mem_web    SRAM write enable, active low
//   mem_addr   SRAM address
//   mem_wdata  SRAM write data (FIFO head)
//   mem_rdata  SRAM read data, one cycle after the read access
//   wb_done    pulse with the NUM_RESULTS-th write
// -----------------------------------------------------------------------------
module result_mem_arbiter
  import result_mem_arbiter_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int NUM_RESULTS   = DEF_NUM_RESULTS,
  parameter int MAX_WR_STREAK = DEF_MAX_WR_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_csn,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_RESULTS - 1);

  logic              fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic              wr_pend, rd_win, wr_win;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  arb_state_e        state_q, state_d;

  wb_fifo #(
    .DATA_W (DATA_W)
  ) u_wb_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (start),
    .push_i  (wr_valid),
    .data_i  (wr_data),
    .pop_i   (wr_win),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign wr_pend   = !fifo_empty;
  assign wr_win    = wr_pend && !rd_win;
  assign wr_ready  = !fifo_full;
  assign mem_wdata = fifo_head;
  assign rd_data   = mem_rdata;
  assign rd_valid  = (state_q == RD);

`ifdef WR_STREAK_LIMIT_EN
  localparam int                  STREAK_W   = $clog2(MAX_WR_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // The read takes the slot once the writes have used up their streak.
  assign rd_win = rd_req && (!wr_pend || (streak_q == STREAK_MAX));

  // The streak only counts writes that make a read wait. Any cycle without a
  // read request starts a fresh streak.
  always_comb begin
    streak_d = streak_q;
    if (start || rd_win || !rd_req) begin
      streak_d = '0;
    end else if (wr_win && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) streak_q <= '0;
    else      streak_q <= streak_d;
  end
`else
  logic unused_streak_cfg;

  assign rd_win            = rd_req && !wr_pend;
  assign unused_streak_cfg = (MAX_WR_STREAK != 0);
`endif

  // Grant decode and next state. The state only remembers the last granted
  // operation, so it needs no transition table.
  always_comb begin
    state_d  = IDLE;
    mem_csn  = 1'b1;
    mem_web  = 1'b1;
    mem_addr = wr_ptr_q;
    rd_gnt   = 1'b0;
    wb_done  = 1'b0;
    wr_ptr_d = wr_ptr_q;
    if (rd_win) begin
      state_d  = RD;
      mem_csn  = 1'b0;
      mem_addr = rd_addr;
      rd_gnt   = 1'b1;
    end else if (wr_win) begin
      state_d  = WR;
      mem_csn  = 1'b0;
      mem_web  = 1'b0;
      if (wr_ptr_q == LAST_ADDR) begin
        wb_done  = 1'b1;
        wr_ptr_d = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
    // start clears the pointer but leaves the state alone, so a read granted
    // in the start cycle still returns rd_valid.
    if (start) wr_ptr_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule
